keypad_operand_entry: RTL and testbench
=======================================

# keypad_operand_entry

Input-side counterpart of the calculator's display path. The display path converts a binary result into decimal digits for the seven-segment display. This block does the reverse: it accepts decoded keypad key strobes, accumulates decimal digits into binary operands, and latches an operator. It then hands operand A, operand B and the operator to the arithmetic core through a req/ack handshake. It sits between the keypad decoder and the calculator's operand registers, and replaces the switch-based operand load.

## Interface
- WIDTH, 8, operand width in bits.
- MAX_VALUE, 255, largest accepted operand; must be ≤ 2^WIDTH−1.
- MAX_DIGITS, 3, maximum decimal digits per operand.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: key_code is valid this cycle.
- key_code  in  4  key code:
  - 0x0–0x9: digits.
  - 0xA: add. 0xB: subtract. 0xC: multiply. 0xD: divide.
  - 0xE: clear.
  - 0xF: equals.
- ack  in  1  arithmetic core has captured the operands.
- req  out  1  operand_a, operand_b and op are valid; held until ack.
- operand_a  out  WIDTH  first operand.
- operand_b  out  WIDTH  second operand.
- op  out  2  operator: add=0, subtract=1, divide=2, multiply=3 (matches the calculator mode encoding).
- entry  out  WIDTH  value currently being typed, for display.
- overflow  out  1  sticky: a digit was rejected.

## Operation
- States:
  - ENTER_A: typing operand A.
  - ENTER_B: typing operand B.
  - REQ: handshake with the core.
- Reset values: state=ENTER_A; req, operand_a, operand_b, op, entry, overflow all 0; digit count 0.
- Digit d in ENTER_A or ENTER_B:
  - next = entry·10 + d, computed as (entry<<3)+(entry<<1)+d at WIDTH+4 bits.
  - Accepted if next ≤ MAX_VALUE and digit count < MAX_DIGITS: entry=next, count+1.
  - Otherwise the digit is dropped, entry is unchanged and overflow is set.
- Leading zeros count as digits.
- Operator in ENTER_A: operand_a=entry (0 if no digits were typed), op latched, entry=0, count=0, go to ENTER_B.
- Operator in ENTER_B:
  - No B digits typed: op is replaced.
  - Otherwise: the key is ignored.
- Equals:
  - In ENTER_A: ignored.
  - In ENTER_B: operand_b=entry, req=1, go to REQ.
- Clear in ENTER_A or ENTER_B: all registers return to their reset values and state goes to ENTER_A.
- REQ state:
  - All keys, including clear, are ignored.
  - When ack is sampled high: req=0, entry=0, count=0, overflow=0, go to ENTER_A.
  - operand_a, operand_b and op hold their values after the handshake.
- ack while req is low has no effect.
- Overflow clears only on clear, on handshake completion or on reset.

## Timing
- Key strobe in cycle n → entry, state and overflow updated at the edge ending cycle n (visible in n+1).
- Equals in cycle n → req high from n+1.
- operand_a, operand_b and op are stable the entire time req is high.
- ack high in cycle m with req high → req low from m+1. Keys are accepted again from m+1.
- key_valid in the same cycle as ack in REQ: the key is discarded.
- reset_n low at any point, including mid-handshake, forces the reset values immediately; req drops asynchronously.
- No combinational path from key_valid or ack to any output.

## Configuration
- KEYPAD_BACKSPACE_EN defined: key 0xE with digit count > 0 is a backspace.
  - entry = entry/10 (constant divide), count−1.
  - overflow and state are unaffected.
  - 0xE with count = 0 performs a full clear.
- KEYPAD_BACKSPACE_EN undefined: 0xE is always a full clear; no divider is synthesized.

## Structure
- Shared package keypad_pkg holds:
  - key-code constants (KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_CLR, KEY_EQ);
  - the op encoding constants;
  - the state enum.
- One sub-module, dec_accumulate: combinational entry·10+d with limit compare. Parameterized by WIDTH, MAX_VALUE; outputs next value and a reject flag.
- The FSM and registers live in the top module.

## Test plan
- Keys 1,2,+,3,4,= → req=1 with operand_a=12, operand_b=34, op=0. Hold ack=0 for 5 cycles: outputs stable. ack=1 → req=0 next cycle.
- Keys 2,5,6 → entry=25, overflow=1. Then 9 → entry=25. Then clear → entry=0, overflow=0.
- Keys 7,×,−,5,= → op=1, operand_a=7, operand_b=5. With B digits present, keys 3,/ leave op unchanged.
- In REQ, press 9 and clear before ack → no change. Key strobe in the same cycle as ack → discarded; entry=0 after.
- reset_n pulsed low while req=1 → req=0, all outputs 0, state ENTER_A.
- With KEYPAD_BACKSPACE_EN: keys 1,2,3,E → entry=12. Then E,E → 0; E again → full clear. Without the macro: 1,2,E → entry=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, operator encoding and entry states shared by the keypad operand path
package keypad_pkg;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;
  typedef enum logic [1:0] {ENTER_A, ENTER_B, REQ} state_t;
  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    return k == KEY_ADD ? OP_ADD : k == KEY_SUB ? OP_SUB : k == KEY_MUL ? OP_MUL : OP_DIV;
  endfunction
endpackage

// File: rtl/keypad_operand_entry_dec_accumulate.sv
// dec_accumulate: entry*10+digit using shift-add, flagging results above MAX_VALUE
module dec_accumulate #(
  parameter int WIDTH     = 8,
  parameter int MAX_VALUE = 255
) (
  input  logic [WIDTH-1:0] entry,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] next,
  output logic             reject
);
  logic [WIDTH+3:0] wide;
  assign wide   = ({4'b0, entry} << 3) + ({4'b0, entry} << 1) + {{WIDTH{1'b0}}, digit};
  assign next   = wide[WIDTH-1:0];
  assign reject = wide > (WIDTH+4)'(MAX_VALUE);
endmodule

// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry: keypad strobes to decimal operands + operator, handed off by req/ack
// Define KEYPAD_BACKSPACE_EN to make 0xE a backspace while digits are present.
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_VALUE  = 255,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             ack,
  output logic             req,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] entry,
  output logic             overflow
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] a_d, b_d, entry_d, acc_next, bs_entry;
  logic [1:0] op_d;
  logic req_d, ovf_d, reject, bs, is_digit, is_op;
  dec_accumulate #(.WIDTH(WIDTH), .MAX_VALUE(MAX_VALUE)) u_acc (
    .entry(entry), .digit(key_code), .next(acc_next), .reject(reject)
  );
`ifdef KEYPAD_BACKSPACE_EN
  assign bs       = cnt != '0;
  assign bs_entry = entry / WIDTH'(10);
`else
  assign bs       = 1'b0;
  assign bs_entry = entry;
`endif
  assign is_digit = key_code <= 4'd9;
  assign is_op    = key_code inside {KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV};
  always_comb begin
    state_d = state;
    req_d   = req;
    a_d     = operand_a;
    b_d     = operand_b;
    op_d    = op;
    entry_d = entry;
    ovf_d   = overflow;
    cnt_d   = cnt;
    if (state == REQ) begin
      if (ack) begin
        req_d   = 1'b0;
        entry_d = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ENTER_A;
      end
    end else if (key_valid) begin
      if (is_digit) begin
        if (!reject && cnt < CW'(MAX_DIGITS)) begin
          entry_d = acc_next;
          cnt_d   = cnt + 1'b1;
        end else
          ovf_d = 1'b1;
      end else if (is_op) begin
        if (state == ENTER_A) begin
          a_d     = entry;
          op_d    = key_to_op(key_code);
          entry_d = '0;
          cnt_d   = '0;
          state_d = ENTER_B;
        end else if (cnt == '0)
          op_d = key_to_op(key_code);
      end else if (key_code == KEY_EQ) begin
        if (state == ENTER_B) begin
          b_d     = entry;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end else if (bs) begin
        entry_d = bs_entry;
        cnt_d   = cnt - 1'b1;
      end else begin
        state_d = ENTER_A;
        a_d     = '0;
        b_d     = '0;
        op_d    = OP_ADD;
        entry_d = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ENTER_A;
      req       <= 1'b0;
      operand_a <= '0;
      operand_b <= '0;
      op        <= OP_ADD;
      entry     <= '0;
      overflow  <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      req       <= req_d;
      operand_a <= a_d;
      operand_b <= b_d;
      op        <= op_d;
      entry     <= entry_d;
      overflow  <= ovf_d;
      cnt       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_keypad_operand_entry.sv
// tb_keypad_operand_entry: directed plus random key streams against a digit-list reference model
module tb_keypad_operand_entry;
  localparam int W = 8;
  logic clk = 0, reset_n = 1, key_valid = 0, ack = 0;
  logic [3:0] key_code = 0;
  logic req, overflow;
  logic [W-1:0] operand_a, operand_b, entry;
  logic [1:0] op;
  always #5 clk = ~clk;
  keypad_operand_entry #(.WIDTH(W), .MAX_VALUE(255), .MAX_DIGITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .key_valid(key_valid), .key_code(key_code), .ack(ack),
    .req(req), .operand_a(operand_a), .operand_b(operand_b), .op(op), .entry(entry),
    .overflow(overflow)
  );
  int n_asserts = 0, n_fail = 0;
  int m_phase, m_a, m_b, m_op, m_req, m_ovf;
  int q[$];
  int op_map[4] = '{0, 1, 3, 2};
  function automatic int qval();
    int v = 0;
    foreach (q[i]) v = v * 10 + q[i];
    return v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic m_clear();
    m_phase = 0; q.delete(); m_a = 0; m_b = 0; m_op = 0; m_req = 0; m_ovf = 0;
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".req"}, {31'b0, req}, m_req);
    chk({tag, ".a"}, {24'b0, operand_a}, m_a);
    chk({tag, ".b"}, {24'b0, operand_b}, m_b);
    chk({tag, ".op"}, {30'b0, op}, m_op);
    chk({tag, ".entry"}, {24'b0, entry}, qval());
    chk({tag, ".ovf"}, {31'b0, overflow}, m_ovf);
  endtask
  task automatic model(input logic kv, input logic [3:0] kc, input logic ak);
    if (m_phase == 2) begin
      if (ak) begin m_req = 0; q.delete(); m_ovf = 0; m_phase = 0; end
    end else if (kv) begin
      if (kc <= 9) begin
        if (qval() * 10 + int'(kc) <= 255 && q.size() < 3) q.push_back(int'(kc));
        else m_ovf = 1;
      end else if (kc >= 10 && kc <= 13) begin
        if (m_phase == 0) begin
          m_a = qval(); m_op = op_map[kc - 10]; q.delete(); m_phase = 1;
        end else if (q.size() == 0) m_op = op_map[kc - 10];
      end else if (kc == 15) begin
        if (m_phase == 1) begin m_b = qval(); m_req = 1; m_phase = 2; end
      end else begin
`ifdef KEYPAD_BACKSPACE_EN
        if (q.size() > 0) void'(q.pop_back()); else
`endif
        m_clear();
      end
    end
  endtask
  task automatic step(input logic kv, input logic [3:0] kc, input logic ak, input string tag);
    @(negedge clk);
    key_valid = kv; key_code = kc; ack = ak;
    @(posedge clk);
    #1;
    key_valid = 0; ack = 0;
    model(kv, kc, ak);
    check_all(tag);
  endtask
  task automatic keys(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      logic [3:0] k;
      byte c = s[i];
      k = (c >= "0" && c <= "9") ? 4'(c - "0") : 4'(c - "A" + 10);
      step(1, k, 0, tag);
    end
  endtask
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset_n = 0;
    #1 m_clear();
    check_all(tag);
    @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    do_reset("rst");
    keys("12A34F", "add");
    chk("add.req_k", {31'b0, req}, 1);
    chk("add.a_k", {24'b0, operand_a}, 12);
    chk("add.b_k", {24'b0, operand_b}, 34);
    chk("add.op_k", {30'b0, op}, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, "hold");
    step(0, 0, 1, "ack");
    chk("ack.req_k", {31'b0, req}, 0);
    keys("256", "ovf");
    chk("ovf.entry_k", {24'b0, entry}, 25);
    chk("ovf.flag_k", {31'b0, overflow}, 1);
    keys("9", "ovf9");
    keys("E", "clr");
    keys("E", "clr2");
    keys("7CB53DF", "opsel");
    chk("opsel.op_k", {30'b0, op}, 1);
    chk("opsel.b_k", {24'b0, operand_b}, 53);
    keys("9E", "reqkeys");
    step(1, 9, 1, "keyack");
    chk("keyack.entry_k", {24'b0, entry}, 0);
    keys("1A2F", "prereset");
    do_reset("midreq");
    keys("000", "zeros");
    keys("0", "zeros4");
    keys("E", "zclr");
`ifdef KEYPAD_BACKSPACE_EN
    keys("E123E", "bs");
    chk("bs.entry_k", {24'b0, entry}, 12);
    keys("EE", "bs2");
    keys("E", "bs3");
`else
    keys("E12E", "noback");
    chk("noback.entry_k", {24'b0, entry}, 0);
`endif
    for (int i = 0; i < 500; i++) begin
      logic kv, ak;
      kv = $urandom_range(0, 3) != 0;
      ak = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      step(kv, 4'($urandom_range(0, 15)), ak, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
